// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and bit-counter sizing.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int cnt_w(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_sub_bit.sv
// Combinational 1-bit full subtractor cell.
// diff = a^b^bin, borrow when a < b + bin.
module full_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic barr
);

   assign diff = a ^ b ^ bin;
   assign barr = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first,
// one full-subtractor cell reused every cycle.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             barr
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] diff_sr_q;
   logic [WIDTH-1:0] diff_sr_d;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt_q;
   logic             borrow_q;
   logic             busy_q;
   logic             done_q;
   logic             barr_q;
   logic             cell_diff;
   logic             cell_barr;

   full_sub_bit u_cell (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (borrow_q),
      .diff (cell_diff),
      .barr (cell_barr)
   );

   // New bit enters at the MSB so the LSB lands at bit 0 last.
   assign diff_sr_d = {cell_diff, diff_sr_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         diff_sr_q <= '0;
         diff_q    <= '0;
         cnt_q     <= '0;
         borrow_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         barr_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr_q   <= a;
                  b_sr_q   <= b;
                  borrow_q <= bin;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr_q    <= a_sr_q >> 1;
               b_sr_q    <= b_sr_q >> 1;
               diff_sr_q <= diff_sr_d;
               borrow_q  <= cell_barr;
               cnt_q     <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  diff_q  <= diff_sr_d;
                  barr_q  <= cell_barr;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign barr = barr_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=4 directed table and corner
// sequences, WIDTH=8 random ops against an arithmetic model.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start4, bin4, busy4, done4, barr4;
   logic [3:0] a4, b4, diff4;
   logic       start8, bin8, busy8, done8, barr8;
   logic [7:0] a8, b8, diff8;

   int errors = 0;
   int checks = 0;

   logic [3:0] held_d4;
   logic       held_b4;

   serial_subtractor #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4),
      .diff(diff4), .barr(barr4)
   );

   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8),
      .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8),
      .diff(diff8), .barr(barr8)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      logic [3:0] d;
      logic       bo;
   } vec_t;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer subtraction, wrapped mod 2^w.
   function automatic void ref_sub(input int w, input int ra,
                                   input int rb, input int rbin,
                                   output int d, output int bo);
      int r;
      r  = ra - rb - rbin;
      bo = (r < 0) ? 1 : 0;
      if (r < 0) r = r + (1 << w);
      d  = r;
   endfunction

   task automatic op4(input logic [3:0] ta, input logic [3:0] tb,
                      input logic tbin, input logic [3:0] ed,
                      input logic eb, input int glitch,
                      input string nm);
      int  lat;
      int  nbusy;
      bit  found;
      bit  stable;
      lat = 0; found = 0; stable = 1;
      @(negedge clk);
      a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      nbusy = busy4 ? 1 : 0;
      for (int k = 1; k <= 10 && !found; k++) begin
         if (k == glitch) begin
            start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; bin4 = 1'b0;
         end else begin
            start4 = 1'b0;
         end
         @(negedge clk);
         if (done4) begin
            found = 1; lat = k;
         end else begin
            if (busy4) nbusy++;
            if (diff4 !== held_d4 || barr4 !== held_b4) stable = 0;
         end
      end
      start4 = 1'b0;
      chk({nm, " latency"}, lat, 4);
      chk({nm, " busy_cycles"}, nbusy, 4);
      chk({nm, " stable"}, stable, 1);
      chk({nm, " diff"}, diff4, ed);
      chk({nm, " barr"}, barr4, eb);
      chk({nm, " busy_at_done"}, busy4, 0);
      @(negedge clk);
      chk({nm, " done_pulse"}, done4, 0);
      held_d4 = ed;
      held_b4 = eb;
   endtask

   task automatic op8(input int idx);
      int  ra, rb, rbin, ed, eb, lat;
      bit  found;
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(255, 0));
      rbin = int'($urandom_range(1, 0));
      if (idx < 4) begin
         rb = ra;
         rbin = idx & 1;
      end
      ref_sub(8, ra, rb, rbin, ed, eb);
      lat = 0; found = 0;
      @(negedge clk);
      a8 = 8'(ra); b8 = 8'(rb); bin8 = 1'(rbin); start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      for (int k = 1; k <= 14 && !found; k++) begin
         @(negedge clk);
         if (done8) begin
            found = 1; lat = k;
         end
      end
      chk($sformatf("rnd%0d lat", idx), lat, 8);
      chk($sformatf("rnd%0d diff", idx), diff8, ed);
      chk($sformatf("rnd%0d barr", idx), barr8, eb);
   endtask

   initial begin
      vec_t tbl[7];
      int   dq[$];
      int   ndone;
      bit   stable;
      bit   quiet;

      tbl[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0};
      tbl[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1};
      tbl[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1};
      tbl[3] = '{4'd5,  4'd5,  1'b1, 4'hF, 1'b1};
      tbl[4] = '{4'hF,  4'd0,  1'b1, 4'hE, 1'b0};
      tbl[5] = '{4'd0,  4'hF,  1'b0, 4'h1, 1'b1};
      tbl[6] = '{4'd7,  4'd7,  1'b0, 4'h0, 1'b0};

      rst_n = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst busy4", busy4, 0);
      chk("rst done4", done4, 0);
      chk("rst diff4", diff4, 0);
      chk("rst barr4", barr4, 0);
      chk("rst busy8", busy8, 0);
      chk("rst diff8", diff8, 0);
      rst_n = 1'b1;
      held_d4 = 4'h0;
      held_b4 = 1'b0;

      for (int i = 0; i < 7; i++) begin
         op4(tbl[i].a, tbl[i].b, tbl[i].bin,
             tbl[i].d, tbl[i].bo, -1, $sformatf("tbl%0d", i));
      end

      op4(4'd12, 4'd5, 1'b0, 4'h7, 1'b0, 2, "ignore_start");
      quiet = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done4 || busy4) quiet = 0;
      end
      chk("ignore_start no_requeue", quiet, 1);

      dq.delete();
      stable = 1;
      @(negedge clk);
      a4 = 4'd10; b4 = 4'd4; bin4 = 1'b0; start4 = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done4) begin
            dq.push_back(n);
            held_d4 = 4'h6;
            held_b4 = 1'b0;
            chk("hold diff", diff4, 4'h6);
         end else if (diff4 !== held_d4 || barr4 !== held_b4) begin
            stable = 0;
         end
      end
      start4 = 1'b0;
      repeat (8) @(negedge clk);
      chk("hold stable", stable, 1);
      chk("hold ops>=3", dq.size() >= 3, 1);
      for (int i = 1; i < dq.size(); i++) begin
         chk($sformatf("hold gap%0d", i), dq[i] - dq[i-1], 6);
      end

      op4(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, -1, "pre_rst");

      @(negedge clk);
      a4 = 4'd2; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst busy", busy4, 0);
      chk("midrst done", done4, 0);
      chk("midrst diff", diff4, 0);
      chk("midrst barr", barr4, 0);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done4) ndone++;
      end
      chk("midrst no_done", ndone, 0);
      held_d4 = 4'h0;
      held_b4 = 1'b0;
      op4(4'd8, 4'd3, 1'b1, 4'h4, 1'b0, -1, "post_rst");

      for (int i = 0; i < 1000; i++) begin
         op8(i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
